// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_pkg : shared floor-count constants and car direction type    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package elevator_pkg;

    localparam int NUM_FLOORS = 7;
    localparam int FLOOR_W    = 3;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/elevator_request_scheduler_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | floor_priority_search : nearest pending floor above/below the car     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module floor_priority_search #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] bitmap,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic [FLOOR_W-1:0]    nearest_above,
    output logic [FLOOR_W-1:0]    nearest_below,
    output logic [FLOOR_W-1:0]    dist_above,
    output logic [FLOOR_W-1:0]    dist_below
);

    localparam logic [FLOOR_W-1:0] C_TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    logic [FLOOR_W-1:0] w_floor;

    // A position reported beyond the shaft is treated as the top floor.
    assign w_floor = (int'(current_floor) >= NUM_FLOORS) ? C_TOP_FLOOR : current_floor;

    always_comb begin
        any_above     = 1'b0;
        any_below     = 1'b0;
        nearest_above = w_floor;
        nearest_below = w_floor;
        dist_above    = '0;
        dist_below    = '0;
        // Scan downward so the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (bitmap[i] && (FLOOR_W'(i) > w_floor)) begin
                any_above     = 1'b1;
                nearest_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (bitmap[i] && (FLOOR_W'(i) < w_floor)) begin
                any_below     = 1'b1;
                nearest_below = FLOOR_W'(i);
            end
        end
        dist_above = nearest_above - w_floor;
        dist_below = w_floor - nearest_below;
    end

endmodule
`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_request_scheduler : request bitmap plus SCAN direction FSM   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  r_nwr,
    input  logic [FLOOR_W-1:0]    requested_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            direction
);

    import elevator_pkg::*;

    logic [NUM_FLOORS-1:0] r_pending;
    dir_t                  r_dir;
    logic [FLOOR_W-1:0]    r_target;
    logic                  r_valid;

    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_pending_next;
    dir_t                  w_dir_next;
    logic [FLOOR_W-1:0]    w_target_next;
    logic                  w_valid_next;

    logic                  w_any_above;
    logic                  w_any_below;
    logic [FLOOR_W-1:0]    w_near_above;
    logic [FLOOR_W-1:0]    w_near_below;
    logic [FLOOR_W-1:0]    w_dist_above;
    logic [FLOOR_W-1:0]    w_dist_below;

    floor_priority_search #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_search (
        .bitmap        (r_pending),
        .current_floor (current_floor),
        .any_above     (w_any_above),
        .any_below     (w_any_below),
        .nearest_above (w_near_above),
        .nearest_below (w_near_below),
        .dist_above    (w_dist_above),
        .dist_below    (w_dist_below)
    );

    // Decoding by comparison keeps out-of-range indices from touching any bit.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_set[i] = !r_nwr && (requested_floor == FLOOR_W'(i));
            w_clr[i] = car_idle && (current_floor == FLOOR_W'(i));
        end
        w_pending_next = (r_pending | w_set) & ~w_clr;
    end

    always_comb begin
        w_dir_next    = r_dir;
        w_target_next = current_floor;
        w_valid_next  = 1'b0;
        case (r_dir)
            DIR_IDLE: begin
                if (w_any_above && w_any_below) begin
                    w_dir_next = (w_dist_above <= w_dist_below) ? DIR_UP : DIR_DOWN;
                end else if (w_any_above) begin
                    w_dir_next = DIR_UP;
                end else if (w_any_below) begin
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_dir_next = DIR_IDLE;
                end
            end
            DIR_UP: begin
                if (w_any_above)      w_dir_next = DIR_UP;
                else if (w_any_below) w_dir_next = DIR_DOWN;
                else                  w_dir_next = DIR_IDLE;
            end
            DIR_DOWN: begin
                if (w_any_below)      w_dir_next = DIR_DOWN;
                else if (w_any_above) w_dir_next = DIR_UP;
                else                  w_dir_next = DIR_IDLE;
            end
            default: w_dir_next = DIR_IDLE;
        endcase

        case (w_dir_next)
            DIR_UP: begin
                w_target_next = w_near_above;
                w_valid_next  = 1'b1;
            end
            DIR_DOWN: begin
                w_target_next = w_near_below;
                w_valid_next  = 1'b1;
            end
            default: begin
                w_target_next = current_floor;
                w_valid_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_dir     <= DIR_IDLE;
            r_target  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_dir     <= w_dir_next;
            r_target  <= w_target_next;
            r_valid   <= w_valid_next;
        end
    end

    assign pending      = r_pending;
    assign direction    = r_dir;
    assign target_floor = r_target;
    assign target_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_elevator_request_scheduler : scoreboard bench with reference model |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_elevator_request_scheduler;

    import elevator_pkg::*;

    localparam int NF = 7;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          r_nwr = 1'b1;
    logic          car_idle = 1'b0;
    logic [FW-1:0] requested_floor = '0;
    logic [FW-1:0] current_floor = '0;
    logic [NF-1:0] pending;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic [1:0]    direction;

    always #5 clk = ~clk;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .r_nwr           (r_nwr),
        .requested_floor (requested_floor),
        .current_floor   (current_floor),
        .car_idle        (car_idle),
        .pending         (pending),
        .target_floor    (target_floor),
        .target_valid    (target_valid),
        .direction       (direction)
    );

    typedef struct {
        logic [NF-1:0] p;
        logic [1:0]    d;
        logic [FW-1:0] tf;
        logic          tv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [NF-1:0] m_p  = '0;
    logic [1:0]    m_d  = DIR_IDLE;
    logic [FW-1:0] m_tf = '0;
    logic          m_tv = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference behaviour for one rising edge, computed from pre-edge state.
    task automatic model_step(input logic nwr, input logic [FW-1:0] rf,
                              input logic [FW-1:0] cf, input logic idle);
        int fe, na, nb;
        logic [1:0] nd;
        fe = (int'(cf) > NF - 1) ? NF - 1 : int'(cf);
        na = -1;
        for (int i = fe + 1; i < NF; i++) if (m_p[i] && na < 0) na = i;
        nb = -1;
        for (int i = fe - 1; i >= 0; i--) if (m_p[i] && nb < 0) nb = i;
        if (m_d == DIR_UP)
            nd = (na >= 0) ? DIR_UP : ((nb >= 0) ? DIR_DOWN : DIR_IDLE);
        else if (m_d == DIR_DOWN)
            nd = (nb >= 0) ? DIR_DOWN : ((na >= 0) ? DIR_UP : DIR_IDLE);
        else if (na >= 0 && nb >= 0)
            nd = ((na - fe) <= (fe - nb)) ? DIR_UP : DIR_DOWN;
        else if (na >= 0)
            nd = DIR_UP;
        else if (nb >= 0)
            nd = DIR_DOWN;
        else
            nd = DIR_IDLE;
        m_d = nd;
        if (nd == DIR_UP) begin
            m_tf = 3'(na); m_tv = 1'b1;
        end else if (nd == DIR_DOWN) begin
            m_tf = 3'(nb); m_tv = 1'b1;
        end else begin
            m_tf = cf; m_tv = 1'b0;
        end
        if (!nwr && int'(rf) < NF) m_p[rf] = 1'b1;
        if (idle && int'(cf) < NF) m_p[cf] = 1'b0;
    endtask

    task automatic step(input logic nwr, input logic [FW-1:0] rf,
                        input logic [FW-1:0] cf, input logic idle, input string tag);
        exp_t e;
        r_nwr = nwr; requested_floor = rf; current_floor = cf; car_idle = idle;
        model_step(nwr, rf, cf, idle);
        e.p = m_p; e.d = m_d; e.tf = m_tf; e.tv = m_tv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "/pend"}, 32'(pending), 32'(e.p));
            check({tag, "/dir"}, 32'(direction), 32'(e.d));
            check({tag, "/tgt"}, 32'(target_floor), 32'(e.tf));
            check({tag, "/vld"}, 32'(target_valid), 32'(e.tv));
        end
    endtask

    // Reset pulse lands between edges; outputs must clear before the next edge.
    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        r_nwr = 1'b1; car_idle = 1'b0;
        #1;
        check({tag, "/pend"}, 32'(pending), 32'd0);
        check({tag, "/dir"}, 32'(direction), 32'(DIR_IDLE));
        check({tag, "/tgt"}, 32'(target_floor), 32'd0);
        check({tag, "/vld"}, 32'(target_valid), 32'd0);
        m_p = '0; m_d = DIR_IDLE; m_tf = '0; m_tv = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #2;
        check("reset/pend", 32'(pending), 32'd0);
        check("reset/dir", 32'(direction), 32'(DIR_IDLE));
        check("reset/tgt", 32'(target_floor), 32'd0);
        check("reset/vld", 32'(target_valid), 32'd0);
        #1 reset_n = 1'b1;

        step(1'b0, 3'd4, 3'd0, 1'b0, "basic_set");
        check("basic/pend10", 32'(pending), 32'h10);
        step(1'b1, 3'd0, 3'd0, 1'b0, "basic_fsm");
        check("basic/up", 32'(direction), 32'(DIR_UP));
        check("basic/t4", 32'(target_floor), 32'd4);
        pulse_reset("rst_a");

        step(1'b0, 3'd5, 3'd3, 1'b0, "scan_s5");
        step(1'b0, 3'd6, 3'd3, 1'b0, "scan_s6");
        step(1'b0, 3'd1, 3'd3, 1'b0, "scan_s1");
        step(1'b1, 3'd0, 3'd3, 1'b0, "scan_run");
        check("scan/up", 32'(direction), 32'(DIR_UP));
        check("scan/t5", 32'(target_floor), 32'd5);
        step(1'b1, 3'd0, 3'd5, 1'b1, "scan_svc5");
        step(1'b1, 3'd0, 3'd5, 1'b0, "scan_go6");
        check("scan/t6", 32'(target_floor), 32'd6);
        step(1'b1, 3'd0, 3'd6, 1'b1, "scan_svc6");
        step(1'b1, 3'd0, 3'd6, 1'b0, "scan_go1");
        check("scan/down", 32'(direction), 32'(DIR_DOWN));
        check("scan/t1", 32'(target_floor), 32'd1);
        step(1'b1, 3'd0, 3'd1, 1'b1, "scan_svc1");
        step(1'b1, 3'd0, 3'd1, 1'b0, "scan_done");
        check("scan/idle", 32'(direction), 32'(DIR_IDLE));
        check("scan/novld", 32'(target_valid), 32'd0);
        pulse_reset("rst_b");

        step(1'b0, 3'd5, 3'd5, 1'b0, "tie_s5");
        step(1'b0, 3'd1, 3'd5, 1'b0, "tie_s1");
        step(1'b1, 3'd0, 3'd3, 1'b0, "tie_eval");
        check("tie/up", 32'(direction), 32'(DIR_UP));
        check("tie/t5", 32'(target_floor), 32'd5);
        pulse_reset("rst_c");

        step(1'b0, 3'd2, 3'd2, 1'b1, "coll");
        check("coll/pend0", 32'(pending), 32'd0);
        step(1'b1, 3'd0, 3'd2, 1'b0, "coll_fsm");
        check("coll/idle", 32'(direction), 32'(DIR_IDLE));

        step(1'b0, 3'd3, 3'd0, 1'b0, "oor_pre");
        step(1'b0, 3'd7, 3'd0, 1'b0, "oor");
        check("oor/pend08", 32'(pending), 32'h08);
        pulse_reset("rst_d");

        step(1'b0, 3'd2, 3'd0, 1'b0, "mid_s2");
        step(1'b0, 3'd6, 3'd0, 1'b0, "mid_s6");
        step(1'b1, 3'd0, 3'd0, 1'b0, "mid_run");
        check("mid/pend44", 32'(pending), 32'h44);
        check("mid/up", 32'(direction), 32'(DIR_UP));
        pulse_reset("mid_rst");
        step(1'b1, 3'd0, 3'd0, 1'b0, "mid_after");

        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Downstream stage of the car's floor-button input panel. Captures each floor request from the panel's active-low write strobe into a pending-request bitmap and drives the button lamps from that bitmap. Runs a SCAN-style direction state machine to choose the next target floor for the car motion controller. Clears a request when the car is stopped at that floor.

## Interface
Parameters:
- `NUM_FLOORS`, default 7: number of floors; the bitmap width.
- `FLOOR_W`, default 3: floor index width; must satisfy `NUM_FLOORS <= 2**FLOOR_W`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `r_nwr`, in, 1: request write strobe from the input panel, active-low; sampled each rising edge.
- `requested_floor`, in, `FLOOR_W`: floor index; valid when `r_nwr`=0.
- `current_floor`, in, `FLOOR_W`: car position from the motion controller.
- `car_idle`, in, 1: 1 = car stopped at `current_floor` with doors open; this services that floor.
- `pending`, out, `NUM_FLOORS`: one bit per floor with an outstanding request; also drives the button lamps.
- `target_floor`, out, `FLOOR_W`: next floor the car must travel to.
- `target_valid`, out, 1: `target_floor` is meaningful.
- `direction`, out, 2: `dir_t` encoding, `DIR_IDLE`=0, `DIR_UP`=1, `DIR_DOWN`=2.

## Operation
- **Set:** on an edge with `r_nwr`=0 and `requested_floor` < `NUM_FLOORS`, set `pending[requested_floor]`.
  - Out-of-range indices are ignored.
  - Setting an already-set bit has no effect.
- **Clear:** on an edge with `car_idle`=1, clear `pending[current_floor]`.
  - A set and a clear to the same bit on the same edge: clear wins. A request for the floor the car is standing at is never latched.
- **Direction FSM:** evaluated on the registered `pending` each edge. "Above" means set bits with index > `current_floor`; "below" means set bits with index < `current_floor`.
  - `DIR_IDLE`:
    - Above only -> `DIR_UP`.
    - Below only -> `DIR_DOWN`.
    - Both -> the direction of the nearer request; equal distance -> `DIR_UP`.
    - Neither -> stay in `DIR_IDLE`.
  - `DIR_UP`:
    - Any above -> stay in `DIR_UP`.
    - Else any below -> `DIR_DOWN`.
    - Else -> `DIR_IDLE`.
  - `DIR_DOWN`: mirror of `DIR_UP`.
- **Target:** computed in the same cycle as the FSM transition, using the next state.
  - UP: nearest set bit above, `target_valid`=1.
  - DOWN: nearest set bit below, `target_valid`=1.
  - IDLE: `target_floor` = `current_floor`, `target_valid`=0.
- `current_floor` >= `NUM_FLOORS` is treated as the top floor for the above/below comparison.

## Timing
- **Reset values:** `pending`=0, `direction`=`DIR_IDLE`, `target_floor`=0, `target_valid`=0.
  - Assertion takes effect immediately (asynchronous) and discards all requests, including mid-travel.
- **Latency:**
  - Strobe sampled at edge N -> `pending` bit visible after edge N.
  - Direction and target reflect it after edge N+1.
- **Clear latency:** `car_idle` sampled at edge N -> bit cleared after edge N. Direction and target update after edge N+1.
- All outputs are registered; there are no combinational input-to-output paths.
- One request per cycle. `r_nwr` held low for k cycles re-sets the same bit k times, which is harmless.

## Structure
- Shared package `elevator_pkg`:
  - Constants `NUM_FLOORS` and `FLOOR_W`.
  - `typedef enum logic [1:0] dir_t`.
  - The panel and the motion controller import the same package.
- Sub-module `floor_priority_search`, combinational.
  - Inputs: bitmap and `current_floor`.
  - Outputs: `any_above`, `any_below`, `nearest_above`, `nearest_below`, and the distance of each.
  - Instantiated once.

## Test plan
- **Reset, then basic request:** release `reset_n`, `current_floor`=0, strobe floor 4 -> `pending`=7'h10 after 1 edge; `direction`=UP and `target_floor`=4 after 2 edges.
- **SCAN ordering:** car at 3 moving UP with pending {1,5,6} -> target 5. Service 5 -> target 6. Service 6 -> `direction`=DOWN, target 1. Service 1 -> `DIR_IDLE`, `target_valid`=0.
- **Tie-break:** IDLE at 3 with pending {1,5} -> UP, target 5.
- **Set/clear collision:** `car_idle`=1 at floor 2 with strobe for floor 2 on the same edge -> `pending[2]` stays 0, and the FSM stays IDLE.
- **Out-of-range request:** strobe `requested_floor`=7 -> `pending` unchanged.
- **Mid-operation reset:** pending {2,6} with direction UP, pulse `reset_n` low between edges -> all outputs return to reset values immediately.
